regfile_scoreboard: RTL

- Dual-issue operand-read and hazard stage: the issue-side client of the 4-read/2-write register file.
- Drives the file's four read addresses and tracks pending destination writes with a busy bit per register.
- Bypasses same-cycle writeback data and stalls on RAW/WAW hazards.
- Registers two operand-ready instructions into one output stage for the execute units.

---
 rtl/regfile_scoreboard_pkg.sv | 30 +++
 rtl/regfile_bypass_mux.sv | 39 +++
 rtl/regfile_scoreboard.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_pkg
//   Shared configuration for the dual-issue operand-read / hazard stage:
//   register-file geometry, FSM state encoding, the issue-slot record and a
//   helper that evaluates the hazard test for one slot.
// ---------------------------------------------------------------------------
package regfile_scoreboard_pkg;

  localparam int NR_REG = 32;               // architectural registers, r0 == 0
  localparam int WIDTH  = 32;               // register data width
  localparam int AW     = $clog2(NR_REG);   // register address width

  // Issue FSM encoding.
  localparam logic [0:0] PAIR   = 1'b0;     // accepting a fresh pair
  localparam logic [0:0] SECOND = 1'b1;     // slot 1 issued, slot 2 pending

  // One issue slot: two sources, one destination, destination write enable.
  typedef struct packed {
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rs_b;
    logic [AW-1:0] rd;
    logic          wen;
  } issue_slot_t;

  // RAW on either source, or WAW on the destination when the slot writes.
  function automatic logic slot_hazard(issue_slot_t s, logic [NR_REG-1:0] eff_busy);
    return eff_busy[s.rs_a] | eff_busy[s.rs_b] | (s.wen & eff_busy[s.rd]);
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// ---------------------------------------------------------------------------
// regfile_bypass_mux
//   Resolves one source operand: r0 reads as zero, otherwise a same-cycle
//   writeback to the source register overrides the register-file read data.
//   Writeback port 2 wins over port 1, matching the file's write order.
//
//   rs        in  source register address
//   rf_data   in  register-file read data for rs
//   wb_*      in  both writeback ports (enable, destination, data)
//   operand   out resolved operand value
// ---------------------------------------------------------------------------
module regfile_bypass_mux
  import regfile_scoreboard_pkg::*;
(
  input  logic [AW-1:0]    rs,
  input  logic [WIDTH-1:0] rf_data,
  input  logic             wb_wen1,
  input  logic [AW-1:0]    wb_rd1,
  input  logic [WIDTH-1:0] wb_data1,
  input  logic             wb_wen2,
  input  logic [AW-1:0]    wb_rd2,
  input  logic [WIDTH-1:0] wb_data2,
  output logic [WIDTH-1:0] operand
);

  always_comb begin
    // NOTE: default assignment first so every path drives operand; without it
    // the if/else chain would infer a latch.
    operand = rf_data;
    if (rs == '0) begin
      operand = '0;
    end else if (wb_wen2 && (wb_rd2 == rs)) begin
      operand = wb_data2;
    end else if (wb_wen1 && (wb_rd1 == rs)) begin
      operand = wb_data1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Dual-issue operand-read and hazard stage in front of a 4-read/2-write
//   register file. Drives the file's read addresses, keeps one busy bit per
//   register for pending writes, bypasses same-cycle writeback data, stalls on
//   RAW/WAW hazards and registers up to two ready instructions into a single
//   output stage. An intra-pair dependency splits the pair over two issues.
//
//   clock, reset          clock; synchronous active-low reset
//   flush                 drop busy bits, output stage and half-issued pair
//   in_valid/in_v2        pair present / slot 2 present
//   in_ready              pair consumed this cycle
//   in_rs*/in_rd*/in_wen* slot sources, destinations, write enables
//   rf_rs1..4             read addresses to the register file (= in_rs1..4)
//   rf_rs1data..4data     register-file read data
//   wb_*                  two writeback ports (enable, destination, data)
//   out_valid/out_v1/v2   output stage valid and per-slot valid
//   out_ready             downstream accepts
//   out_op1..4            resolved operands
//   out_rd*/out_wen*      destinations and write enables
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_v2,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [AW-1:0]    in_rd1,
  input  logic             in_wen1,
  input  logic [AW-1:0]    in_rs3,
  input  logic [AW-1:0]    in_rs4,
  input  logic [AW-1:0]    in_rd2,
  input  logic             in_wen2,
  output logic [AW-1:0]    rf_rs1,
  output logic [AW-1:0]    rf_rs2,
  output logic [AW-1:0]    rf_rs3,
  output logic [AW-1:0]    rf_rs4,
  input  logic [WIDTH-1:0] rf_rs1data,
  input  logic [WIDTH-1:0] rf_rs2data,
  input  logic [WIDTH-1:0] rf_rs3data,
  input  logic [WIDTH-1:0] rf_rs4data,
  input  logic [AW-1:0]    wb_rd1,
  input  logic [AW-1:0]    wb_rd2,
  input  logic             wb_wen1,
  input  logic             wb_wen2,
  input  logic [WIDTH-1:0] wb_data1,
  input  logic [WIDTH-1:0] wb_data2,
  output logic             out_valid,
  output logic             out_v1,
  output logic             out_v2,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_op1,
  output logic [WIDTH-1:0] out_op2,
  output logic [WIDTH-1:0] out_op3,
  output logic [WIDTH-1:0] out_op4,
  output logic [AW-1:0]    out_rd1,
  output logic [AW-1:0]    out_rd2,
  output logic             out_wen1,
  output logic             out_wen2
);

  logic [0:0]        state, state_nxt;
  logic [NR_REG-1:0] busy, clr, set, eff_busy;
  issue_slot_t       slot1, slot2;
  logic              h1, h2, ip, room, can_act;
  logic              fire_both, fire_first, fire_second;
  logic              issue1, issue2, load;
  logic [WIDTH-1:0]  op1, op2, op3, op4;

  // Read addresses go straight to the register file.
  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;
  assign rf_rs3 = in_rs3;
  assign rf_rs4 = in_rs4;

  assign slot1 = '{rs_a: in_rs1, rs_b: in_rs2, rd: in_rd1, wen: in_wen1};
  assign slot2 = '{rs_a: in_rs3, rs_b: in_rs4, rd: in_rd2, wen: in_wen2};

  // Writeback clears; r0 is never tracked so bit 0 stays zero.
  always_comb begin
    clr = '0;
    for (int r = 1; r < NR_REG; r++) begin
      clr[r] = (wb_wen1 && (wb_rd1 == AW'(r))) || (wb_wen2 && (wb_rd2 == AW'(r)));
    end
  end

  // A writeback landing this cycle resolves the hazard; its data is bypassed.
  assign eff_busy = busy & ~clr;

  assign h1 = slot_hazard(slot1, eff_busy);
  assign h2 = slot_hazard(slot2, eff_busy);

  // Slot 2 depends on slot 1's result (RAW) or overwrites it (WAW).
  assign ip = in_v2 & in_wen1 & (in_rd1 != '0) &
              ((in_rs3 == in_rd1) | (in_rs4 == in_rd1) | (in_wen2 & (in_rd2 == in_rd1)));

  assign room    = ~out_valid | out_ready;
  assign can_act = reset & ~flush;

  assign fire_both   = can_act & (state == PAIR) & in_valid & room & ~h1 &
                       (~in_v2 | ~h2) & ~ip;
  assign fire_first  = can_act & (state == PAIR) & in_valid & room & ~h1 & ip;
  // The pair is held upstream; only slot 2 remains to issue.
  assign fire_second = can_act & (state == SECOND) & room & ~h2;

  assign issue1   = fire_both | fire_first;
  assign issue2   = (fire_both & in_v2) | fire_second;
  assign load     = issue1 | issue2;
  assign in_ready = fire_both | fire_second;

  always_comb begin
    set = '0;
    for (int r = 1; r < NR_REG; r++) begin
      set[r] = (issue1 && in_wen1 && (in_rd1 == AW'(r))) ||
               (issue2 && in_wen2 && (in_rd2 == AW'(r)));
    end
  end

  always_comb begin
    state_nxt = state;
    if (fire_first) begin
      state_nxt = SECOND;
    end else if (fire_second) begin
      state_nxt = PAIR;
    end
  end

  regfile_bypass_mux u_mux1 (
    .rs(in_rs1), .rf_data(rf_rs1data),
    .wb_wen1(wb_wen1), .wb_rd1(wb_rd1), .wb_data1(wb_data1),
    .wb_wen2(wb_wen2), .wb_rd2(wb_rd2), .wb_data2(wb_data2),
    .operand(op1)
  );

  regfile_bypass_mux u_mux2 (
    .rs(in_rs2), .rf_data(rf_rs2data),
    .wb_wen1(wb_wen1), .wb_rd1(wb_rd1), .wb_data1(wb_data1),
    .wb_wen2(wb_wen2), .wb_rd2(wb_rd2), .wb_data2(wb_data2),
    .operand(op2)
  );

  regfile_bypass_mux u_mux3 (
    .rs(in_rs3), .rf_data(rf_rs3data),
    .wb_wen1(wb_wen1), .wb_rd1(wb_rd1), .wb_data1(wb_data1),
    .wb_wen2(wb_wen2), .wb_rd2(wb_rd2), .wb_data2(wb_data2),
    .operand(op3)
  );

  regfile_bypass_mux u_mux4 (
    .rs(in_rs4), .rf_data(rf_rs4data),
    .wb_wen1(wb_wen1), .wb_rd1(wb_rd1), .wb_data1(wb_data1),
    .wb_wen2(wb_wen2), .wb_rd2(wb_rd2), .wb_data2(wb_data2),
    .operand(op4)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the operand/destination registers are reset as well because
      // their reset value is visible on the output ports.
      busy      <= '0;
      state     <= PAIR;
      out_valid <= 1'b0;
      out_v1    <= 1'b0;
      out_v2    <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_op3   <= '0;
      out_op4   <= '0;
      out_rd1   <= '0;
      out_rd2   <= '0;
      out_wen1  <= 1'b0;
      out_wen2  <= 1'b0;
    end else if (flush) begin
      busy      <= '0;
      state     <= PAIR;
      out_valid <= 1'b0;
      out_v1    <= 1'b0;
      out_v2    <= 1'b0;
    end else begin
      // Set wins over a same-cycle clear of the same register.
      busy  <= (busy & ~clr) | set;
      state <= state_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_v1    <= issue1;
        out_v2    <= issue2;
        out_op1   <= op1;
        out_op2   <= op2;
        out_op3   <= op3;
        out_op4   <= op4;
        out_rd1   <= in_rd1;
        out_rd2   <= in_rd2;
        // A slot that did not issue must not look like a write downstream.
        out_wen1  <= in_wen1 & issue1;
        out_wen2  <= in_wen2 & issue2;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_v1    <= 1'b0;
        out_v2    <= 1'b0;
      end
    end
  end

endmodule
